// File: rtl/mvm_mac_ctrl.sv
// Matrix-vector multiply sequencer: walks M row by row, streams M[row][col]
// and x[col] into a saturating MAC, clears the accumulator between rows and
// writes each finished row sum to the output memory.
module mvm_mac_ctrl #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ACC_W  = 28,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned MA_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    parameter int unsigned XA_W   = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int unsigned YA_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [MA_W-1:0]   m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic [XA_W-1:0]   x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid_in,
    output logic              mac_clear,
    input  logic [ACC_W-1:0]  mac_f,
    input  logic              mac_valid_out,
    output logic              y_wr_en,
    output logic [YA_W-1:0]   y_addr,
    output logic [ACC_W-1:0]  y_data
);

    // vcnt must be able to hold COLS itself, not just COLS-1
    localparam int unsigned VC_W = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [YA_W-1:0]   row_q, row_d;
    logic [XA_W-1:0]   col_q, col_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mac_valid_in_q, mac_valid_in_d;
    logic              mac_clear_q, mac_clear_d;
    logic              y_wr_en_q, y_wr_en_d;
    logic [MA_W-1:0]   m_addr_q, m_addr_d;
    logic [XA_W-1:0]   x_addr_q, x_addr_d;
    logic [YA_W-1:0]   y_addr_q, y_addr_d;
    logic [ACC_W-1:0]  y_data_q, y_data_d;

    logic              strobe_c;
    logic              last_strobe_c;

    // Memory read data goes straight to the MAC operands
    assign mac_a = m_data;
    assign mac_b = x_data;

    assign busy         = busy_q;
    assign done         = done_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_clear    = mac_clear_q;
    assign y_wr_en      = y_wr_en_q;
    assign m_addr       = m_addr_q;
    assign x_addr       = x_addr_q;
    assign y_addr       = y_addr_q;
    assign y_data       = y_data_q;

    // MAC result strobes only count while a row is in flight
    assign strobe_c      = mac_valid_out && ((state_q == FEED) || (state_q == DRAIN));
    assign last_strobe_c = strobe_c && (vcnt_q == VC_W'(COLS - 1));

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            row_q          <= '0;
            col_q          <= '0;
            vcnt_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mac_valid_in_q <= 1'b0;
            mac_clear_q    <= 1'b0;
            y_wr_en_q      <= 1'b0;
            m_addr_q       <= '0;
            x_addr_q       <= '0;
            y_addr_q       <= '0;
            y_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            vcnt_q         <= vcnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mac_valid_in_q <= mac_valid_in_d;
            mac_clear_q    <= mac_clear_d;
            y_wr_en_q      <= y_wr_en_d;
            m_addr_q       <= m_addr_d;
            x_addr_q       <= x_addr_d;
            y_addr_q       <= y_addr_d;
            y_data_q       <= y_data_d;
        end
    end

    // Next-state and next-output logic; pulse outputs default low
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        vcnt_d         = vcnt_q;
        m_addr_d       = m_addr_q;
        x_addr_d       = x_addr_q;
        y_addr_d       = y_addr_q;
        y_data_d       = y_data_q;
        done_d         = 1'b0;
        mac_clear_d    = 1'b0;
        y_wr_en_d      = 1'b0;
        // operands appear one cycle after their FEED address
        mac_valid_in_d = (state_q == FEED);

        if (strobe_c && (vcnt_q != VC_W'(COLS))) begin
            vcnt_d = vcnt_q + 1'b1;
        end
        // capture the sum from the same cycle as the final strobe
        if (last_strobe_c) begin
            y_data_d = mac_f;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CLEAR;
                    row_d       = '0;
                    mac_clear_d = 1'b1;
                end
            end
            CLEAR: begin
                col_d    = '0;
                vcnt_d   = '0;
                m_addr_d = MA_W'(row_q * COLS);
                x_addr_d = '0;
                state_d  = FEED;
            end
            FEED: begin
                if (col_q == XA_W'(COLS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    col_d    = col_q + 1'b1;
                    m_addr_d = m_addr_q + 1'b1;
                    x_addr_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if ((vcnt_q == VC_W'(COLS)) || last_strobe_c) begin
                    state_d   = WRITE;
                    y_wr_en_d = 1'b1;
                    y_addr_d  = row_q;
                end
            end
            WRITE: begin
                if (row_q == YA_W'(ROWS - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    row_d       = row_q + 1'b1;
                    state_d     = CLEAR;
                    mac_clear_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mvm_mac_ctrl.sv
// Bench for mvm_mac_ctrl: memories and a variable-latency saturating MAC
// around the controller, y results checked against a plain-arithmetic model.
module tb_mvm_mac_ctrl;

    localparam int unsigned DW = 14;
    localparam int unsigned AW = 28;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam longint      SMAX = 134217727;
    localparam longint      SMIN = -134217728;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic          busy, done;
    logic [3:0]    m_addr;
    logic [1:0]    x_addr;
    logic [DW-1:0] m_data, x_data, mac_a, mac_b;
    logic          mac_valid_in, mac_clear, mac_valid_out;
    logic [AW-1:0] mac_f;
    logic          y_wr_en;
    logic [1:0]    y_addr;
    logic [AW-1:0] y_data;

    mvm_mac_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .m_addr(m_addr), .m_data(m_data), .x_addr(x_addr), .x_data(x_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in),
        .mac_clear(mac_clear), .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .y_wr_en(y_wr_en), .y_addr(y_addr), .y_data(y_data)
    );

    // 1x1 instance
    logic          s_start, s_busy, s_done, s_vin, s_clr, s_vout, s_wr;
    logic [0:0]    s_m_addr, s_x_addr, s_y_addr;
    logic [DW-1:0] s_m_data, s_x_data, s_a, s_b;
    logic [AW-1:0] s_f, s_y_data;

    mvm_mac_ctrl #(.ROWS(1), .COLS(1)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .m_addr(s_m_addr), .m_data(s_m_data), .x_addr(s_x_addr), .x_data(s_x_data),
        .mac_a(s_a), .mac_b(s_b), .mac_valid_in(s_vin),
        .mac_clear(s_clr), .mac_f(s_f), .mac_valid_out(s_vout),
        .y_wr_en(s_wr), .y_addr(s_y_addr), .y_data(s_y_data)
    );

    function automatic longint clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // ---------------- environment: memories and MAC ----------------
    logic signed [DW-1:0] mm [R*C];
    logic signed [DW-1:0] xm [C];
    logic signed [DW-1:0] sm [2];
    logic signed [DW-1:0] sx [2];

    always @(posedge clk) begin
        m_data   <= mm[m_addr];
        x_data   <= xm[x_addr];
        s_m_data <= sm[s_m_addr];
        s_x_data <= sx[s_x_addr];
    end

    int            lat;
    logic [AW-1:0] acc;
    logic          vp [4];
    logic [AW-1:0] fp [4];

    function automatic logic [AW-1:0] mac_next(input logic [AW-1:0] a_acc,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a_acc)) + longint'($signed(a)) * longint'($signed(b));
        return AW'(clamp(s));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || mac_clear) begin
            acc <= '0;
            for (int i = 0; i < 4; i++) begin vp[i] <= 1'b0; fp[i] <= '0; end
        end else begin
            acc   <= mac_valid_in ? mac_next(acc, mac_a, mac_b) : acc;
            vp[0] <= mac_valid_in;
            fp[0] <= mac_valid_in ? mac_next(acc, mac_a, mac_b) : acc;
            for (int i = 1; i < 4; i++) begin vp[i] <= vp[i-1]; fp[i] <= fp[i-1]; end
        end
    end
    assign mac_f         = fp[lat-1];
    assign mac_valid_out = vp[lat-1];

    logic [AW-1:0] s_acc;
    logic          s_vo_q;
    always @(posedge clk or posedge reset) begin
        if (reset || s_clr) begin
            s_acc  <= '0;
            s_vo_q <= 1'b0;
        end else begin
            s_acc  <= s_vin ? mac_next(s_acc, s_a, s_b) : s_acc;
            s_vo_q <= s_vin;
        end
    end
    assign s_f    = s_acc;
    assign s_vout = s_vo_q;

    // ---------------- monitor ----------------
    int            n_vin, n_clr, n_ovl, n_done, n_busy, s_nwr, s_ndone;
    logic [1:0]    wa_q [$];
    logic [AW-1:0] wd_q [$];
    logic [AW-1:0] s_wd;
    logic [0:0]    s_wa;

    always @(negedge clk) begin
        if (!reset) begin
            if (mac_valid_in) n_vin++;
            if (mac_clear) n_clr++;
            if (mac_valid_in && mac_clear) n_ovl++;
            if (done) n_done++;
            if (busy) n_busy++;
            if (y_wr_en) begin wa_q.push_back(y_addr); wd_q.push_back(y_data); end
            if (s_wr) begin s_nwr++; s_wd = s_y_data; s_wa = s_y_addr; end
            if (s_done) s_ndone++;
        end
    end

    task automatic reset_counts();
        n_vin = 0; n_clr = 0; n_ovl = 0; n_done = 0; n_busy = 0;
        s_nwr = 0; s_ndone = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Row result: saturating running sum of M[r][c]*x[c]
    function automatic logic [AW-1:0] ref_y(input int r);
        longint s = 0;
        for (int c = 0; c < C; c++) s = clamp(s + longint'(mm[r*C+c]) * longint'(xm[c]));
        return AW'(s);
    endfunction

    task automatic run_once(input bit hold, output int cyc);
        bit seen = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            cyc++;
            if (done) begin seen = 1; break; end
        end
        start = 1'b0;
        check_eq("done_seen", 64'(seen), 64'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int cyc);
        check_eq({tag, "_nwr"}, 64'(wa_q.size()), 64'(R));
        for (int i = 0; i < wa_q.size() && i < R; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'(i));
            check_eq($sformatf("%s_y%0d", tag, i), 64'(wd_q[i]), 64'(ref_y(i)));
        end
        check_eq({tag, "_nvin"}, 64'(n_vin), 64'(R*C));
        check_eq({tag, "_nclr"}, 64'(n_clr), 64'(R));
        check_eq({tag, "_ovl"}, 64'(n_ovl), 64'd0);
        check_eq({tag, "_ndone"}, 64'(n_done), 64'd1);
        check_eq({tag, "_nbusy"}, 64'(n_busy), 64'(cyc));
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic logic signed [DW-1:0] rnd_elem();
        case ($urandom_range(0, 3))
            0: return 14'sd8191;
            1: return -14'sd8192;
            default: return DW'($urandom);
        endcase
    endfunction

    int cyc;

    initial begin
        reset = 1'b1; start = 1'b0; s_start = 1'b0; lat = 1;
        for (int i = 0; i < R*C; i++) mm[i] = '0;
        for (int i = 0; i < C; i++) xm[i] = '0;
        sm[0] = -14'sd3; sm[1] = '0; sx[0] = 14'sd5; sx[1] = '0;
        reset_counts();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_vin", 64'(mac_valid_in), 64'd0);
        check_eq("rst_clr", 64'(mac_clear), 64'd0);
        check_eq("rst_wr", 64'(y_wr_en), 64'd0);
        check_eq("rst_addr", 64'({m_addr, x_addr, y_addr}), 64'd0);
        check_eq("rst_ydata", 64'(y_data), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // all-ones matrix, x = 1..4
        for (int i = 0; i < R*C; i++) mm[i] = 14'sd1;
        for (int i = 0; i < C; i++) xm[i] = DW'(i + 1);
        lat = $urandom_range(1, 4);
        reset_counts();
        run_once(0, cyc);
        check_run("ones", cyc);
        for (int i = 0; i < wd_q.size() && i < R; i++)
            check_eq($sformatf("ones_k%0d", i), 64'(wd_q[i]), 64'd10);

        // accumulator must clear between rows
        for (int i = 0; i < R*C; i++) mm[i] = (i < C) ? 14'sd100 : 14'sd0;
        for (int i = 0; i < C; i++) xm[i] = 14'sd1;
        lat = $urandom_range(1, 4);
        reset_counts();
        run_once(0, cyc);
        check_run("clr", cyc);
        if (wd_q.size() >= 2) begin
            check_eq("clr_k0", 64'(wd_q[0]), 64'd400);
            check_eq("clr_k1", 64'(wd_q[1]), 64'd0);
        end

        // saturation passes through unchanged
        for (int c = 0; c < C; c++) begin
            mm[c] = 14'sd8191; mm[C+c] = -14'sd8192; xm[c] = 14'sd8191;
            mm[2*C+c] = rnd_elem(); mm[3*C+c] = rnd_elem();
        end
        lat = $urandom_range(1, 4);
        reset_counts();
        run_once(0, cyc);
        check_run("sat", cyc);
        if (wd_q.size() >= 2) begin
            check_eq("sat_k0", 64'(wd_q[0]), 64'h7FFFFFF);
            check_eq("sat_k1", 64'(wd_q[1]), 64'h8000000);
        end

        // start held high for the whole run: one computation only
        for (int i = 0; i < R*C; i++) mm[i] = rnd_elem();
        for (int i = 0; i < C; i++) xm[i] = rnd_elem();
        lat = $urandom_range(1, 4);
        reset_counts();
        run_once(1, cyc);
        check_run("hold", cyc);

        // reset in the middle of row 2 FEED
        reset_counts();
        begin
            bit hit = 0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if (wa_q.size() == 2 && m_addr == 4'(2*C + 1)) begin hit = 1; break; end
                @(negedge clk);
            end
            check_eq("mid_found", 64'(hit), 64'd1);
            check_eq("mid_vin_pre", 64'(mac_valid_in), 64'd1);
            #1 reset = 1'b1;
            #1;
            check_eq("mid_busy", 64'(busy), 64'd0);
            check_eq("mid_vin", 64'(mac_valid_in), 64'd0);
            check_eq("mid_wr", 64'(y_wr_en), 64'd0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < R*C; i++) mm[i] = 14'sd1;
        for (int i = 0; i < C; i++) xm[i] = DW'(i + 1);
        reset_counts();
        run_once(0, cyc);
        check_run("rerun", cyc);
        for (int i = 0; i < wd_q.size() && i < R; i++)
            check_eq($sformatf("rerun_k%0d", i), 64'(wd_q[i]), 64'd10);

        // random matrices and MAC latencies
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < R*C; i++) mm[i] = rnd_elem();
            for (int i = 0; i < C; i++) xm[i] = rnd_elem();
            lat = $urandom_range(1, 4);
            reset_counts();
            run_once(0, cyc);
            check_run($sformatf("rnd%0d", t), cyc);
        end

        // 1x1 instance: -3 * 5
        reset_counts();
        begin
            bit seen = 0;
            @(negedge clk);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (s_done) begin seen = 1; break; end
                @(negedge clk);
            end
            check_eq("s_done_seen", 64'(seen), 64'd1);
            repeat (4) @(negedge clk);
        end
        check_eq("s_nwr", 64'(s_nwr), 64'd1);
        check_eq("s_addr", 64'(s_wa), 64'd0);
        check_eq("s_y", 64'(s_wd), 64'hFFFFFF1);
        check_eq("s_ndone", 64'(s_ndone), 64'd1);
        check_eq("s_idle", 64'(s_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
